// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the data-memory access unit.
// Size encodings, FSM states and the latched request bundle.
package mem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'b00,
      SZ_HALF  = 2'b01,
      SZ_WORD  = 2'b10,
      SZ_WORDX = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_e;

   typedef struct packed {
      logic [31:0] addr;
      size_e       size;
      logic        sign_ext;
      logic [31:0] st_value;
      logic        is_load;
      logic        is_store;
   } mem_req_t;

   // Low address bits actually used; ignored bits are cleared.
   function automatic logic [1:0] lane_lo(
      size_e      sz,
      logic [1:0] lo
   );
      logic [1:0] r;
      unique case (sz)
         SZ_BYTE: r = lo;
         SZ_HALF: r = {lo[1], 1'b0};
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] byte_en(
      size_e      sz,
      logic [1:0] lo
   );
      logic [3:0] r;
      unique case (sz)
         SZ_BYTE: r = 4'b0001 << lo;
         SZ_HALF: r = lo[1] ? 4'b1100 : 4'b0011;
         default: r = 4'b1111;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] st_align(
      size_e       sz,
      logic [31:0] v
   );
      logic [31:0] r;
      unique case (sz)
         SZ_BYTE: r = {4{v[7:0]}};
         SZ_HALF: r = {2{v[15:0]}};
         default: r = v;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] ld_extract(
      size_e       sz,
      logic [1:0]  lo,
      logic        sx,
      logic [31:0] w
   );
      logic [31:0] sh;
      logic [31:0] r;
      sh = w >> {lo, 3'b000};
      unique case (sz)
         SZ_BYTE: r = {{24{sx & sh[7]}}, sh[7:0]};
         SZ_HALF: r = {{16{sx & sh[15]}}, sh[15:0]};
         default: r = w;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_word_ram.sv
// Word-organised data RAM with byte enables.
// Whole array clears on reset; read port is combinational.
module mem_word_ram #(
   parameter int DEPTH = 256
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [3:0]               be,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [31:0]              wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [31:0]              rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit in front of a word RAM.
// Define MEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        mem_r_en,
   input  logic        mem_w_en,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] st_value,
   output logic        stall,
   output logic        rd_valid,
`ifdef MEM_ALIGN_CHECK_EN
   output logic [31:0] rd_data,
   output logic        misalign
`else
   output logic [31:0] rd_data
`endif
);

   localparam int AW = $clog2(DEPTH);

   state_e      state;
   state_e      state_nx;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nx;
   mem_req_t    req_q;
   logic [31:0] rd_q;
   logic        accept;
   logic        done;
   logic        mis;
   logic [1:0]  lo;
   logic [31:0] rdata;
   logic [31:0] ld_val;
   logic        ram_we;

   assign accept = rst && (state == IDLE) && req_valid
                 && (mem_r_en || mem_w_en);

`ifdef MEM_ALIGN_CHECK_EN
   logic mis_q;
   logic mis_in;

   always_comb begin
      mis_in = 1'b0;
      unique case (size_e'(size))
         SZ_HALF:          mis_in = addr[0];
         SZ_WORD, SZ_WORDX: mis_in = |addr[1:0];
         default:          mis_in = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mis_q <= 1'b0;
      end else if (accept) begin
         mis_q <= mis_in;
      end
   end

   assign mis      = mis_q;
   assign misalign = done && mis_q;
`else
   assign mis = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         req_q <= '0;
         rd_q  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (accept) begin
            req_q.addr     <= addr;
            req_q.size     <= size_e'(size);
            req_q.sign_ext <= sign_ext;
            req_q.st_value <= st_value;
            req_q.is_load  <= mem_r_en && !mem_w_en;
            req_q.is_store <= mem_w_en;
         end
         if (rd_valid) begin
            rd_q <= ld_val;
         end
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_nx   = '0;
               state_nx = (LATENCY == 0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (cnt == 4'(LATENCY - 1)) begin
               cnt_nx   = '0;
               state_nx = DONE;
            end else begin
               cnt_nx = cnt + 4'd1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign done  = (state == DONE);
   assign stall = accept || (state == WAIT);

   assign lo     = lane_lo(req_q.size, req_q.addr[1:0]);
   assign ld_val = mis ? '0
                 : ld_extract(req_q.size, lo,
                              req_q.sign_ext, rdata);

   assign rd_valid = done && req_q.is_load;
   assign rd_data  = rd_valid ? ld_val : rd_q;
   assign ram_we   = done && req_q.is_store && !mis;

   mem_word_ram #(
      .DEPTH (DEPTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst),
      .we    (ram_we),
      .be    (byte_en(req_q.size, lo)),
      .waddr (req_q.addr[AW+1:2]),
      .wdata (st_align(req_q.size, req_q.st_value)),
      .raddr (req_q.addr[AW+1:2]),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array reference model.
// A second instance with zero latency checks single-cycle completion.
`timescale 1ns/1ps
module tb_mem_access_unit;

   localparam int DEPTH = 256;
   localparam int L     = 2;
   localparam int NB    = DEPTH * 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        mem_r_en = 1'b0;
   logic        mem_w_en = 1'b0;
   logic [1:0]  size = 2'b00;
   logic        sign_ext = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] st_value = '0;

   logic        stall, rd_valid;
   logic [31:0] rd_data;
   logic        stall0, rd_valid0;
   logic [31:0] rd_data0;
`ifdef MEM_ALIGN_CHECK_EN
   logic        misalign, misalign0;
`endif

   always #5 clk = ~clk;

   mem_access_unit #(.DEPTH(DEPTH), .LATENCY(L)) u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .size(size), .sign_ext(sign_ext), .addr(addr),
      .st_value(st_value), .stall(stall),
      .rd_valid(rd_valid),
`ifdef MEM_ALIGN_CHECK_EN
      .misalign(misalign),
`endif
      .rd_data(rd_data)
   );

   mem_access_unit #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
      .size(size), .sign_ext(sign_ext), .addr(addr),
      .st_value(st_value), .stall(stall0),
      .rd_valid(rd_valid0),
`ifdef MEM_ALIGN_CHECK_EN
      .misalign(misalign0),
`endif
      .rd_data(rd_data0)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(string name, logic [31:0] act,
                      logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h @cyc %0d",
                  name, act, exp, cyc);
      end
   endtask

   // reference model
   logic [7:0]  mem_m [NB];
   bit          active = 0;
   int          t_acc = 0;
   bit          m_load, m_store, m_sx, m_mis;
   logic [1:0]  m_sz;
   logic [31:0] m_addr, m_val;
   logic [31:0] hold = '0;

   function automatic bit mis_of(logic [31:0] a,
                                 logic [1:0] sz);
`ifdef MEM_ALIGN_CHECK_EN
      return (sz == 2'b01 && a[0])
          || (sz[1] && a[1:0] != 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
      hold   = '0;
      active = 0;
   endfunction

   function automatic void m_write(logic [31:0] a,
                                   logic [1:0] sz,
                                   logic [31:0] v);
      int b;
      b = int'(a[9:0]) & (NB - 1);
      if (sz == 2'b00) begin
         mem_m[b] = v[7:0];
      end else if (sz == 2'b01) begin
         b = b & ~1;
         mem_m[b]     = v[7:0];
         mem_m[b + 1] = v[15:8];
      end else begin
         b = b & ~3;
         for (int k = 0; k < 4; k++)
            mem_m[b + k] = v[8*k +: 8];
      end
   endfunction

   function automatic logic [31:0] m_read(logic [31:0] a,
                                          logic [1:0] sz,
                                          bit sx);
      int b;
      logic [15:0] h;
      b = int'(a[9:0]) & (NB - 1);
      if (sz == 2'b00) begin
         return sx ? {{24{mem_m[b][7]}}, mem_m[b]}
                   : {24'h0, mem_m[b]};
      end else if (sz == 2'b01) begin
         b = b & ~1;
         h = {mem_m[b + 1], mem_m[b]};
         return sx ? {{16{h[15]}}, h} : {16'h0, h};
      end
      b = b & ~3;
      return {mem_m[b + 3], mem_m[b + 2],
              mem_m[b + 1], mem_m[b]};
   endfunction

   logic        e_stall, e_valid, e_mis;
   logic [31:0] e_data;

   always @(negedge clk) begin
      e_stall = 1'b0;
      e_valid = 1'b0;
      e_mis   = 1'b0;
      e_data  = hold;
      if (!rst) begin
         e_data = '0;
      end else if (active) begin
         if (cyc >= t_acc && cyc <= t_acc + L)
            e_stall = 1'b1;
         if (cyc == t_acc + L + 1) begin
            e_valid = m_load;
            e_mis   = m_mis;
            if (m_load)
               e_data = m_mis ? '0 : m_read(m_addr, m_sz, m_sx);
         end
      end
      chk("stall", 32'(stall), 32'(e_stall));
      chk("rd_valid", 32'(rd_valid), 32'(e_valid));
      chk("rd_data", rd_data, e_data);
`ifdef MEM_ALIGN_CHECK_EN
      chk("misalign", 32'(misalign), 32'(e_mis));
`endif
      if (rst && active && cyc == t_acc + L + 1) begin
         if (m_store && !m_mis) m_write(m_addr, m_sz, m_val);
         if (m_load) hold = e_data;
         active = 0;
      end
   end

   logic s0_issue, s0_next, v0_next;
   logic [31:0] d0_next;

   task automatic access(bit w, bit r, logic [1:0] sz,
                         bit sx, logic [31:0] a,
                         logic [31:0] d);
      @(posedge clk); #2;
      req_valid = 1'b1;
      mem_w_en  = w;
      mem_r_en  = r;
      size      = sz;
      sign_ext  = sx;
      addr      = a;
      st_value  = d;
      if (w || r) begin
         active  = 1;
         t_acc   = cyc;
         m_store = w;
         m_load  = r && !w;
         m_sz    = sz;
         m_sx    = sx;
         m_addr  = a;
         m_val   = d;
         m_mis   = mis_of(a, sz);
      end
      @(negedge clk);
      s0_issue = stall0;
      @(posedge clk); #2;
      req_valid = 1'b0;
      mem_w_en  = ~w;
      mem_r_en  = ~r;
      size      = ~sz;
      sign_ext  = ~sx;
      addr      = ~a;
      st_value  = ~d;
      @(negedge clk);
      s0_next = stall0;
      v0_next = rd_valid0;
      d0_next = rd_data0;
      if (L > 0) begin
         repeat (L) @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic ld(string name, logic [1:0] sz, bit sx,
                     logic [31:0] a, logic [31:0] lit);
      access(1'b0, 1'b1, sz, sx, a, 32'h0);
      chk(name, rd_data, lit);
      chk({name, "_v"}, 32'(rd_valid), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: no finish by 100us");
      $fatal(1, "timeout");
   end

   initial begin
      m_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_data", rd_data, 32'h0);
      chk("reset_stall", 32'(stall), 32'd0);
      @(posedge clk); #2;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      access(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF);
      ld("word_ld", 2'b10, 0, 32'h10, 32'hDEADBEEF);
      chk("lat0_stall_t", 32'(s0_issue), 32'd1);
      chk("lat0_stall_t1", 32'(s0_next), 32'd0);
      chk("lat0_valid_t1", 32'(v0_next), 32'd1);
      chk("lat0_data_t1", d0_next, 32'hDEADBEEF);

      access(1, 0, 2'b00, 0, 32'h13, 32'h80);
      ld("byte_sx", 2'b00, 1, 32'h13, 32'hFFFFFF80);
      ld("byte_zx", 2'b00, 0, 32'h13, 32'h00000080);
      ld("word_mix", 2'b10, 0, 32'h10, 32'h80ADBEEF);

      access(1, 0, 2'b01, 0, 32'h16, 32'h1234);
      ld("half_hi", 2'b01, 1, 32'h16, 32'h00001234);
      access(1, 0, 2'b01, 0, 32'h14, 32'h8001);
      ld("half_sx", 2'b01, 1, 32'h14, 32'hFFFF8001);
      ld("half_w", 2'b10, 0, 32'h14, 32'h12348001);

      access(1, 0, 2'b10, 0, 32'h400, 32'h1);
      ld("wrap", 2'b10, 0, 32'h0, 32'h1);

      access(1, 1, 2'b10, 0, 32'h8, 32'hA5A5A5A5);
      chk("both_no_valid", 32'(rd_valid), 32'd0);
      ld("both_ld", 2'b10, 0, 32'h8, 32'hA5A5A5A5);

      access(0, 0, 2'b10, 0, 32'h8, 32'h0);
      chk("ignored_hold", rd_data, 32'hA5A5A5A5);

      access(1, 0, 2'b11, 0, 32'h30, 32'hCAFEF00D);
      ld("size3", 2'b11, 0, 32'h30, 32'hCAFEF00D);
      ld("byte31", 2'b00, 1, 32'h31, 32'hFFFFFFF0);

`ifdef MEM_ALIGN_CHECK_EN
      ld("mis_ld", 2'b10, 0, 32'h12, 32'h0);
      chk("mis_flag", 32'(misalign), 32'd1);
      access(1, 0, 2'b10, 0, 32'h12, 32'hFFFFFFFF);
      chk("mis_st_flag", 32'(misalign), 32'd1);
      ld("mis_unchanged", 2'b10, 0, 32'h10, 32'h80ADBEEF);
`else
      ld("force_word", 2'b10, 0, 32'h12, 32'h80ADBEEF);
      ld("force_half", 2'b01, 0, 32'h13, 32'h000080AD);
`endif

      @(posedge clk); #2;
      req_valid = 1'b1;
      mem_w_en  = 1'b1;
      mem_r_en  = 1'b0;
      size      = 2'b10;
      addr      = 32'h20;
      st_value  = 32'h55;
      active    = 1;
      t_acc     = cyc;
      m_store   = 1;
      m_load    = 0;
      m_sz      = 2'b10;
      m_sx      = 0;
      m_addr    = 32'h20;
      m_val     = 32'h55;
      m_mis     = 0;
      @(posedge clk); #2;
      req_valid = 1'b0;
      mem_w_en  = 1'b0;
      rst       = 1'b0;
      m_clear();
      @(negedge clk);
      chk("rst_mid_stall", 32'(stall), 32'd0);
      chk("rst_mid_data", rd_data, 32'h0);
      @(posedge clk); #2;
      rst = 1'b1;
      ld("rst_ld20", 2'b10, 0, 32'h20, 32'h0);
      ld("rst_ld10", 2'b10, 0, 32'h10, 32'h0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DEPTH, 256, number of 32-bit words in data memory (power of two, >=4).
REQ-002 SHALL have parameter LATENCY, 2, extra wait cycles per access (0..15).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  in  1  access request present.
REQ-006 SHALL have port mem_r_en  in  1  load request.
REQ-007 SHALL have port mem_w_en  in  1  store request.
REQ-008 SHALL have port size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-009 SHALL have port sign_ext  in  1  sign-extend sub-word loads when 1, zero-extend when 0.
REQ-010 SHALL have port addr  in  32  byte address (ALU result).
REQ-011 SHALL have port st_value  in  32  store data, right-aligned.
REQ-012 SHALL have port stall  out  1  pipeline hold request.
REQ-013 SHALL have port rd_valid  out  1  one-cycle load-completion pulse.
REQ-014 SHALL have port rd_data  out  32  load result, extended per size/sign_ext.
REQ-015 SHALL have port misalign  out  1  misaligned-access pulse (present only with MEM_ALIGN_CHECK_EN).

Function
REQ-016 SHALL use states IDLE, WAIT, DONE.
REQ-017 SHALL accept a request in IDLE when req_valid and (mem_r_en or mem_w_en); req_valid without either enable is ignored.
REQ-018 SHALL latch addr, size, sign_ext, st_value and operation at acceptance; later input changes have no effect.
REQ-019 SHALL go IDLE->WAIT on acceptance (LATENCY>0) or IDLE->DONE (LATENCY=0); WAIT counts LATENCY cycles then ->DONE; DONE->IDLE unconditionally.
REQ-020 SHALL, for request accepted in cycle t, complete in cycle t+1+LATENCY (DONE); stall=1 combinationally in cycles t..t+LATENCY, stall=0 in DONE and idle cycles.
REQ-021 SHALL not accept a new request in DONE; back-to-back accesses spaced by LATENCY+2 cycles.
REQ-022 SHALL, when mem_r_en and mem_w_en both set, perform the store only (no rd_valid).
REQ-023 SHALL index word addr[log2(DEPTH)+1:2]; higher address bits ignored (wrap-around).
REQ-024 SHALL commit stores on the clock edge ending DONE, updating only the addressed byte lanes (byte: lane addr[1:0]; half: lanes addr[1]*2..+1; word: all four).
REQ-025 SHALL drive rd_valid=1 and rd_data in DONE for loads; rd_data holds last load value otherwise.
REQ-026 SHALL extract loads from lane(s) per REQ-024 and extend to 32 bits per sign_ext.

Reset
REQ-027 SHALL on rst low force state IDLE, counter 0, stall 0, rd_valid 0, rd_data 0, misalign 0, and all memory words 0.
REQ-028 SHALL on reset mid-access abort the access; a pending store is not committed.

Configuration
REQ-029 SHALL, with MEM_ALIGN_CHECK_EN defined, flag half with addr[0]=1 or word with addr[1:0]!=0: timing unchanged, store suppressed, rd_data=0, misalign=1 in DONE (rd_valid still pulses for loads).
REQ-030 SHALL, without MEM_ALIGN_CHECK_EN, omit the misalign port and force ignored low bits (half: addr[0]; word: addr[1:0]) to 0.

Structure
REQ-031 SHALL place size encodings and state enum in shared package mem_pkg.
REQ-032 SHALL implement storage in sub-module mem_word_ram (DEPTH x 32, 4-bit byte enable, async-clear, combinational read).

Verification
REQ-033 SHALL cover: LATENCY=2, word store 0xDEADBEEF @0x10 then word load @0x10 -> stall 3 cycles each, rd_valid at t+3, rd_data=0xDEADBEEF.
REQ-034 SHALL cover: byte store 0x80 @0x13, load byte @0x13 sign_ext=1 -> 0xFFFFFF80; sign_ext=0 -> 0x00000080; word @0x10 -> 0x80ADBEEF.
REQ-035 SHALL cover: LATENCY=0, load @0x10 -> stall 1 cycle, rd_valid next cycle.
REQ-036 SHALL cover: DEPTH=256, store 0x1 @0x400 -> load @0x0 returns 0x1 (wrap).
REQ-037 SHALL cover: rst low during WAIT of store 0x55 @0x20 -> IDLE, outputs 0, load @0x20 returns 0.
REQ-038 SHALL cover (MEM_ALIGN_CHECK_EN): word load @0x12 -> misalign=1, rd_data=0; word store @0x12 leaves memory unchanged.
